// File: rtl/unidad_control_vec.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// unidad_control_vec
//
// Pipelined control unit for the vector processor. Each accepted opcode is
// decoded into a 14-bit control word that then walks through four stages:
// decode, EXE, memory and write-back. Each stage drives its own slice of the
// control word. A vector instruction (reg_rdv or reg_wrv set) is replayed
// into decode once per beat (VLEN/LANES beats). Fetch is held off until the
// last beat sits in decode.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   opcode_in/instr_valid opcode from fetch and its valid flag
//   instr_ready           unit accepts an opcode this cycle
//   stall_in              freezes every stage, the FSM and the beat counter
//   flush                 kills the decode and EXE stages
//   decode stage          sel_pc, sel_dest, reg_rdv, reg_rds, valid_d
//   EXE stage             sel_op, sel_ad, sel_int, opcode_out, beat_e, valid_e
//   memory stage          sum_mem, sel_mem, sel_data, mem_wr, valid_m
//   write-back stage      sel_wb, reg_wrv, reg_wrs, beat_w, valid_w
//
// Control word layout, MSB first:
//   [13] sel_pc  [12] sel_dest [11] reg_rdv [10] reg_rds
//   [9]  sel_op  [8]  sel_ad   [7]  sel_int
//   [6]  sum_mem [5]  sel_mem  [4]  sel_data [3] mem_wr
//   [2]  sel_wb  [1]  reg_wrv  [0]  reg_wrs
// ---------------------------------------------------------------------------
module unidad_control_vec #(
  parameter int OPCODE_W = 4,
  parameter int VLEN     = 8,
  parameter int LANES    = 2,
  parameter int BEAT_W   = ((VLEN / LANES) > 1) ? $clog2(VLEN / LANES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode_in,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                stall_in,
  input  logic                flush,
  output logic                sel_pc,
  output logic                sel_dest,
  output logic                reg_rdv,
  output logic                reg_rds,
  output logic                valid_d,
  output logic                sel_op,
  output logic                sel_ad,
  output logic                sel_int,
  output logic [OPCODE_W-1:0] opcode_out,
  output logic [BEAT_W-1:0]   beat_e,
  output logic                valid_e,
  output logic                sum_mem,
  output logic                sel_mem,
  output logic                sel_data,
  output logic                mem_wr,
  output logic                valid_m,
  output logic                sel_wb,
  output logic                reg_wrv,
  output logic                reg_wrs,
  output logic [BEAT_W-1:0]   beat_w,
  output logic                valid_w
);

  localparam int BEATS = ((VLEN / LANES) > 1) ? (VLEN / LANES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [OPCODE_W+3:0] MAX_CODE = 15;

  typedef enum logic {
    IDLE,
    REPEAT
  } state_t;

  // Opcodes wider than 4 bits that exceed 4'b1111 fall onto the default row.
  function automatic logic [13:0] decode_op(input logic [OPCODE_W-1:0] opc);
    logic [OPCODE_W+3:0] ext;
    logic [13:0]         cw;
    ext = {4'b0000, opc};
    cw  = 14'b10000000000000;
    if (ext <= MAX_CODE) begin
      case (ext[3:0])
        4'b0000:                   cw = 14'b00000000000000;
        4'b0001, 4'b0010:          cw = 14'b00100000000110;
        4'b0011:                   cw = 14'b01100000110010;
        4'b0100:                   cw = 14'b01100000111000;
        4'b0101, 4'b1010, 4'b1011: cw = 14'b00110010000100;
        4'b0110, 4'b0111,
        4'b1000, 4'b1001:          cw = 14'b00111010000100;
        4'b1100:                   cw = 14'b01000000000101;
        4'b1101:                   cw = 14'b00010100000101;
        4'b1110:                   cw = 14'b01100000010010;
        4'b1111:                   cw = 14'b11100001011000;
        default:                   cw = 14'b10000000000000;
      endcase
    end
    return cw;
  endfunction

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [13:0]           hold_cw_q, hold_cw_d;
  logic [OPCODE_W-1:0]   hold_opc_q, hold_opc_d;

  logic                  dec_valid_q, dec_valid_d;
  logic [13:0]           dec_cw_q, dec_cw_d;
  logic [OPCODE_W-1:0]   dec_opc_q, dec_opc_d;
  logic [BEAT_W-1:0]     dec_beat_q, dec_beat_d;

  logic                  exe_valid_q, exe_valid_d;
  logic [9:0]            exe_cw_q, exe_cw_d;
  logic [OPCODE_W-1:0]   exe_opc_q, exe_opc_d;
  logic [BEAT_W-1:0]     exe_beat_q, exe_beat_d;

  logic                  mem_valid_q, mem_valid_d;
  logic [6:0]            mem_cw_q, mem_cw_d;
  logic [BEAT_W-1:0]     mem_beat_q, mem_beat_d;

  logic                  wb_valid_q, wb_valid_d;
  logic [2:0]            wb_cw_q, wb_cw_d;
  logic [BEAT_W-1:0]     wb_beat_q, wb_beat_d;

  logic [13:0]           new_cw;
  logic                  new_is_vec;
  logic                  last_beat;
  logic                  accept;
  logic [BEAT_W-1:0]     next_beat;

  assign new_cw     = decode_op(opcode_in);
  assign new_is_vec = new_cw[11] | new_cw[1];
  // The last beat of a vector is sitting in decode: fetch may issue again so
  // the next instruction follows it with no bubble.
  assign last_beat  = (state_q == REPEAT) && (beat_cnt_q == LAST_BEAT);
  assign next_beat  = beat_cnt_q + BEAT_W'(1);

  assign instr_ready = reset & ~stall_in & ((state_q == IDLE) | last_beat);
  assign accept      = instr_valid & instr_ready & ~flush;

  // Next-state logic for the sequencer and all four stage registers.
  // Everything holds by default, which is exactly what a stall needs.
  // Flush wipes decode/EXE even under a stall. The EXE instruction is
  // killed, so memory receives a bubble rather than the flushed entry.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    hold_cw_d   = hold_cw_q;
    hold_opc_d  = hold_opc_q;
    dec_valid_d = dec_valid_q;
    dec_cw_d    = dec_cw_q;
    dec_opc_d   = dec_opc_q;
    dec_beat_d  = dec_beat_q;
    exe_valid_d = exe_valid_q;
    exe_cw_d    = exe_cw_q;
    exe_opc_d   = exe_opc_q;
    exe_beat_d  = exe_beat_q;
    mem_valid_d = mem_valid_q;
    mem_cw_d    = mem_cw_q;
    mem_beat_d  = mem_beat_q;
    wb_valid_d  = wb_valid_q;
    wb_cw_d     = wb_cw_q;
    wb_beat_d   = wb_beat_q;

    if (flush) begin
      state_d     = IDLE;
      beat_cnt_d  = '0;
      dec_valid_d = 1'b0;
      dec_cw_d    = '0;
      dec_opc_d   = '0;
      dec_beat_d  = '0;
      exe_valid_d = 1'b0;
      exe_cw_d    = '0;
      exe_opc_d   = '0;
      exe_beat_d  = '0;
    end else if (!stall_in) begin
      exe_valid_d = dec_valid_q;
      exe_cw_d    = dec_cw_q[9:0];
      exe_opc_d   = dec_opc_q;
      exe_beat_d  = dec_beat_q;

      if ((state_q == REPEAT) && !last_beat) begin
        // Replay the held word; sel_pc only survives on the final beat.
        dec_valid_d  = 1'b1;
        dec_cw_d     = hold_cw_q;
        dec_cw_d[13] = hold_cw_q[13] & (next_beat == LAST_BEAT);
        dec_opc_d    = hold_opc_q;
        dec_beat_d   = next_beat;
        beat_cnt_d   = next_beat;
      end else if (accept) begin
        dec_valid_d = 1'b1;
        dec_cw_d    = new_cw;
        dec_opc_d   = opcode_in;
        dec_beat_d  = '0;
        beat_cnt_d  = '0;
        hold_cw_d   = new_cw;
        hold_opc_d  = opcode_in;
        if (new_is_vec && (BEATS > 1)) begin
          dec_cw_d[13] = 1'b0;
          state_d      = REPEAT;
        end else begin
          state_d      = IDLE;
        end
      end else begin
        dec_valid_d = 1'b0;
        dec_cw_d    = '0;
        dec_opc_d   = '0;
        dec_beat_d  = '0;
        beat_cnt_d  = '0;
        state_d     = IDLE;
      end
    end

    if (!stall_in) begin
      mem_valid_d = flush ? 1'b0 : exe_valid_q;
      mem_cw_d    = flush ? '0 : exe_cw_q[6:0];
      mem_beat_d  = flush ? '0 : exe_beat_q;
      wb_valid_d  = mem_valid_q;
      wb_cw_d     = mem_cw_q[2:0];
      wb_beat_d   = mem_beat_q;
    end
  end

  // State register for the sequencer and every pipeline stage; reset is
  // synchronous and active-low and leaves no stage valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      hold_cw_q   <= '0;
      hold_opc_q  <= '0;
      dec_valid_q <= 1'b0;
      dec_cw_q    <= '0;
      dec_opc_q   <= '0;
      dec_beat_q  <= '0;
      exe_valid_q <= 1'b0;
      exe_cw_q    <= '0;
      exe_opc_q   <= '0;
      exe_beat_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_cw_q    <= '0;
      mem_beat_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_cw_q     <= '0;
      wb_beat_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      hold_cw_q   <= hold_cw_d;
      hold_opc_q  <= hold_opc_d;
      dec_valid_q <= dec_valid_d;
      dec_cw_q    <= dec_cw_d;
      dec_opc_q   <= dec_opc_d;
      dec_beat_q  <= dec_beat_d;
      exe_valid_q <= exe_valid_d;
      exe_cw_q    <= exe_cw_d;
      exe_opc_q   <= exe_opc_d;
      exe_beat_q  <= exe_beat_d;
      mem_valid_q <= mem_valid_d;
      mem_cw_q    <= mem_cw_d;
      mem_beat_q  <= mem_beat_d;
      wb_valid_q  <= wb_valid_d;
      wb_cw_q     <= wb_cw_d;
      wb_beat_q   <= wb_beat_d;
    end
  end

  // An empty stage drives all of its outputs low.
  assign valid_d    = dec_valid_q;
  assign sel_pc     = dec_valid_q & dec_cw_q[13];
  assign sel_dest   = dec_valid_q & dec_cw_q[12];
  assign reg_rdv    = dec_valid_q & dec_cw_q[11];
  assign reg_rds    = dec_valid_q & dec_cw_q[10];

  assign valid_e    = exe_valid_q;
  assign sel_op     = exe_valid_q & exe_cw_q[9];
  assign sel_ad     = exe_valid_q & exe_cw_q[8];
  assign sel_int    = exe_valid_q & exe_cw_q[7];
  assign opcode_out = exe_valid_q ? exe_opc_q : '0;
  assign beat_e     = exe_valid_q ? exe_beat_q : '0;

  assign valid_m    = mem_valid_q;
  assign sum_mem    = mem_valid_q & mem_cw_q[6];
  assign sel_mem    = mem_valid_q & mem_cw_q[5];
  assign sel_data   = mem_valid_q & mem_cw_q[4];
  assign mem_wr     = mem_valid_q & mem_cw_q[3];

  assign valid_w    = wb_valid_q;
  assign sel_wb     = wb_valid_q & wb_cw_q[2];
  assign reg_wrv    = wb_valid_q & wb_cw_q[1];
  assign reg_wrs    = wb_valid_q & wb_cw_q[0];
  assign beat_w     = wb_valid_q ? wb_beat_q : '0;

endmodule

// File: tb/tb_unidad_control_vec.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_unidad_control_vec
//
// Directed bench for unidad_control_vec. The main DUT uses the default
// parameters (4-bit opcodes, 4 beats per vector). A second instance with
// 5-bit opcodes exercises the out-of-table default decode row.
// ---------------------------------------------------------------------------
module tb_unidad_control_vec;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] opc;
    logic       stall;
    logic       flush;
    logic       rdy;
    logic [4:0] d;
    logic [9:0] e;
    logic [4:0] m;
    logic [5:0] w;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode_in;
  logic       instr_valid, stall_in, flush, instr_ready;
  logic       sel_pc, sel_dest, reg_rdv, reg_rds, valid_d;
  logic       sel_op, sel_ad, sel_int, valid_e;
  logic [3:0] opcode_out;
  logic [1:0] beat_e, beat_w;
  logic       sum_mem, sel_mem, sel_data, mem_wr, valid_m;
  logic       sel_wb, reg_wrv, reg_wrs, valid_w;

  logic [4:0] opcode5, opcode_out5;
  logic       iv5, ready5, stall5, flush5;
  logic       sel_pc5, sel_dest5, reg_rdv5, reg_rds5, valid_d5;
  logic       sel_op5, sel_ad5, sel_int5, valid_e5;
  logic [1:0] beat_e5, beat_w5;
  logic       sum_mem5, sel_mem5, sel_data5, mem_wr5, valid_m5;
  logic       sel_wb5, reg_wrv5, reg_wrs5, valid_w5;

  int checksTotal  = 0;
  int checksPassed = 0;

  vec_t vecs[26];
  vec_t hv;

  always #5 clk = ~clk;

  unidad_control_vec dut (
    .clk(clk), .reset(reset), .opcode_in(opcode_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall_in(stall_in), .flush(flush),
    .sel_pc(sel_pc), .sel_dest(sel_dest), .reg_rdv(reg_rdv), .reg_rds(reg_rds),
    .valid_d(valid_d), .sel_op(sel_op), .sel_ad(sel_ad), .sel_int(sel_int),
    .opcode_out(opcode_out), .beat_e(beat_e), .valid_e(valid_e),
    .sum_mem(sum_mem), .sel_mem(sel_mem), .sel_data(sel_data), .mem_wr(mem_wr),
    .valid_m(valid_m), .sel_wb(sel_wb), .reg_wrv(reg_wrv), .reg_wrs(reg_wrs),
    .beat_w(beat_w), .valid_w(valid_w)
  );

  unidad_control_vec #(.OPCODE_W(5)) dut5 (
    .clk(clk), .reset(reset), .opcode_in(opcode5), .instr_valid(iv5),
    .instr_ready(ready5), .stall_in(stall5), .flush(flush5),
    .sel_pc(sel_pc5), .sel_dest(sel_dest5), .reg_rdv(reg_rdv5), .reg_rds(reg_rds5),
    .valid_d(valid_d5), .sel_op(sel_op5), .sel_ad(sel_ad5), .sel_int(sel_int5),
    .opcode_out(opcode_out5), .beat_e(beat_e5), .valid_e(valid_e5),
    .sum_mem(sum_mem5), .sel_mem(sel_mem5), .sel_data(sel_data5), .mem_wr(mem_wr5),
    .valid_m(valid_m5), .sel_wb(sel_wb5), .reg_wrv(reg_wrv5), .reg_wrs(reg_wrs5),
    .beat_w(beat_w5), .valid_w(valid_w5)
  );

  // Stage outputs gathered in the same bit order as the vector table.
  logic [4:0]  act_d, act_m, act5_d, act5_m;
  logic [9:0]  act_e;
  logic [10:0] act5_e;
  logic [5:0]  act_w, act5_w;
  assign act_d  = {valid_d, sel_pc, sel_dest, reg_rdv, reg_rds};
  assign act_e  = {valid_e, sel_op, sel_ad, sel_int, opcode_out, beat_e};
  assign act_m  = {valid_m, sum_mem, sel_mem, sel_data, mem_wr};
  assign act_w  = {valid_w, sel_wb, reg_wrv, reg_wrs, beat_w};
  assign act5_d = {valid_d5, sel_pc5, sel_dest5, reg_rdv5, reg_rds5};
  assign act5_e = {valid_e5, sel_op5, sel_ad5, sel_int5, opcode_out5, beat_e5};
  assign act5_m = {valid_m5, sum_mem5, sel_mem5, sel_data5, mem_wr5};
  assign act5_w = {valid_w5, sel_wb5, reg_wrv5, reg_wrs5, beat_w5};

  // Drive the main DUT inputs for the coming clock edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] o,
                               input logic s, input logic f);
    reset       = r;
    instr_valid = v;
    opcode_in   = o;
    stall_in    = s;
    flush       = f;
  endtask

  // Compare one observed value against its expected value and log misses.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // One cycle: drive at negedge, check ready before the edge, then check
  // every stage just after the edge.
  task automatic runRow(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v.rst, v.iv, v.opc, v.stall, v.flush);
    #1;
    checkOutput({tag, " ready"}, 32'(instr_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    checkOutput({tag, " dec"}, 32'(act_d), 32'(v.d));
    checkOutput({tag, " exe"}, 32'(act_e), 32'(v.e));
    checkOutput({tag, " mem"}, 32'(act_m), 32'(v.m));
    checkOutput({tag, " wb"},  32'(act_w), 32'(v.w));
  endtask

  // Runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    opcode5 = 5'b00000;
    iv5     = 1'b0;
    stall5  = 1'b0;
    flush5  = 1'b0;

    // {rst, iv, opc, stall, flush, ready, dec, exe, mem, wb}
    // Reset held three cycles with a pending opcode, then released.
    vecs[0]  = '{1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 5'b0, 10'b0, 5'b0, 6'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 5'b0, 10'b0, 5'b0, 6'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 5'b0, 10'b0, 5'b0, 6'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b0, 6'b0};
    // Scalar 1101 through all four stages.
    vecs[4]  = '{1'b1, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b1, 5'b10001, 10'b0, 5'b0, 6'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b1_010_1101_00, 5'b0, 6'b0};
    vecs[6]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b1_0000, 6'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b0, 6'b1_101_00};
    // Vector 0001 over four beats, 1100 waiting and taken on the last beat.
    vecs[8]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 5'b1_0010, 10'b0, 5'b0, 6'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 5'b1_0010, 10'b1_000_0001_00, 5'b0, 6'b0};
    vecs[10] = '{1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 5'b1_0010, 10'b1_000_0001_01, 5'b1_0000, 6'b0};
    vecs[11] = '{1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 5'b1_0010, 10'b1_000_0001_10, 5'b1_0000, 6'b1_110_00};
    vecs[12] = '{1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b1, 5'b1_0100, 10'b1_000_0001_11, 5'b1_0000, 6'b1_110_01};
    vecs[13] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b1_000_1100_00, 5'b1_0000, 6'b1_110_10};
    vecs[14] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b1_0000, 6'b1_110_11};
    vecs[15] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b0, 6'b1_101_00};
    // Vector 1111 with a two-cycle stall while beat 1 sits in decode.
    vecs[16] = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 5'b1_0110, 10'b0, 5'b0, 6'b0};
    vecs[17] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'b1_0110, 10'b1_000_1111_00, 5'b0, 6'b0};
    vecs[18] = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 5'b1_0110, 10'b1_000_1111_00, 5'b0, 6'b0};
    vecs[19] = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 5'b1_0110, 10'b1_000_1111_00, 5'b0, 6'b0};
    vecs[20] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'b1_0110, 10'b1_000_1111_01, 5'b1_1011, 6'b0};
    vecs[21] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'b1_1110, 10'b1_000_1111_10, 5'b1_1011, 6'b1_000_00};
    vecs[22] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b1_000_1111_11, 5'b1_1011, 6'b1_000_01};
    vecs[23] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b1_1011, 6'b1_000_10};
    vecs[24] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b0, 6'b1_000_11};
    vecs[25] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b0, 6'b0};

    for (int i = 0; i < 26; i++) runRow(vecs[i], $sformatf("row %0d", i));

    // Flush while beat 2 of a vector sits in decode; a waiting 1100 must not
    // slip in on the flush cycle.
    hv = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 5'b1_0010, 10'b0, 5'b0, 6'b0};
    runRow(hv, "flush 0");
    hv = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'b1_0010, 10'b1_000_0001_00, 5'b0, 6'b0};
    runRow(hv, "flush 1");
    hv = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'b1_0010, 10'b1_000_0001_01, 5'b1_0000, 6'b0};
    runRow(hv, "flush 2");
    hv = '{1'b1, 1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 5'b0, 10'b0, 5'b0, 6'b1_110_00};
    runRow(hv, "flush 3");
    checkOutput("flush ready after", 32'(instr_ready), 32'd1);
    hv = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b0, 6'b0};
    runRow(hv, "flush 4");

    // Reset in the middle of a vector abandons the remaining beats.
    hv = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 5'b1_0010, 10'b0, 5'b0, 6'b0};
    runRow(hv, "rstmid 0");
    hv = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'b1_0010, 10'b1_000_0001_00, 5'b0, 6'b0};
    runRow(hv, "rstmid 1");
    hv = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'b0, 10'b0, 5'b0, 6'b0};
    runRow(hv, "rstmid 2");
    hv = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b0, 6'b0};
    runRow(hv, "rstmid 3");
    hv = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 5'b0, 10'b0, 5'b0, 6'b0};
    runRow(hv, "rstmid 4");

    // 5-bit opcode 10110 is outside the table: only sel_pc in decode.
    @(negedge clk);
    iv5     = 1'b1;
    opcode5 = 5'b10110;
    #1;
    checkOutput("w5 ready", 32'(ready5), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("w5 dec", 32'(act5_d), 32'(5'b11000));
    @(negedge clk);
    iv5 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("w5 exe", 32'(act5_e), 32'(11'b1_000_10110_00));
    checkOutput("w5 dec bubble", 32'(act5_d), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("w5 mem", 32'(act5_m), 32'(5'b10000));
    @(posedge clk);
    #1;
    checkOutput("w5 wb", 32'(act5_w), 32'(6'b1_000_00));
    checkOutput("w5 ready idle", 32'(ready5), 32'd1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
